// File: rtl/sort_n_seq.sv
// Sequential odd-even transposition sorter: one compare-exchange phase per clock, N phases per vector.
// The swap count it reports equals the inversion count of the input vector.
module sort_n_seq #(
  parameter int WIDTH  = 4,
  parameter int N      = 4,
  parameter int SIGNED = 0,
  parameter int CW     = $clog2(N*(N-1)/2+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic                 in_desc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [CW-1:0]        out_swaps,
  output logic                 busy
);

  localparam int PW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t                    state_q, state_d;
  logic [N-1:0][WIDTH-1:0]   work_q, work_d;
  logic                      desc_q, desc_d;
  logic [CW-1:0]             swaps_q, swaps_d;
  logic [PW-1:0]             phase_q, phase_d;
  logic                      out_valid_q, out_valid_d;

  // True when a (lower index) and b (higher index) must be exchanged; ties never swap.
  function automatic logic out_of_order(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic             desc);
    logic gt_ab;
    logic lt_ab;
    if (SIGNED != 0) begin
      gt_ab = $signed(a) > $signed(b);
      lt_ab = $signed(a) < $signed(b);
    end else begin
      gt_ab = a > b;
      lt_ab = a < b;
    end
    return desc ? lt_ab : gt_ab;
  endfunction

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    desc_d      = desc_q;
    swaps_d     = swaps_q;
    phase_d     = phase_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          desc_d  = in_desc;
          swaps_d = '0;
          phase_d = '0;
          state_d = SORT;
        end
      end
      SORT: begin
        // Pairs starting at even indices in even phases, odd indices in odd phases; pairs are disjoint.
        for (int i = 0; i < N-1; i++) begin
          if (i[0] == phase_q[0]) begin
            if (out_of_order(work_q[i], work_q[i+1], desc_q)) begin
              work_d[i]   = work_q[i+1];
              work_d[i+1] = work_q[i];
              swaps_d     = swaps_d + CW'(1);
            end
          end
        end
        if (phase_q == PW'(N-1)) begin
          phase_d     = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      desc_q      <= 1'b0;
      swaps_q     <= '0;
      phase_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      desc_q      <= desc_d;
      swaps_q     <= swaps_d;
      phase_q     <= phase_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q == SORT) || (state_q == DONE);
  assign out_valid = out_valid_q;
  assign out_data  = work_q;
  assign out_swaps = swaps_q;

endmodule
